// File: rtl/fadd_pkg.sv
// Shared float32 types and helpers for the window accumulator.
package fadd_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  // Denormals count as zero: only the exponent field is inspected.
  function automatic logic is_zero(fp32_t v);
    return (v.exp == 8'd0);
  endfunction

endpackage

// File: rtl/fadder.sv
// Combinational float32 adder for normal, non-cancelling operands.
// Rounds to nearest-even; tiny results flush to zero.
module fadder
  import fadd_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result
);

  fp32_t             x, y;
  logic [7:0]        shamt;
  logic [26:0]       mx, my, my_sh, lost, m, d;
  logic [27:0]       s;
  logic [4:0]        lz;
  logic signed [9:0] e;
  logic              round_up;
  logic [24:0]       mr;

  always_comb begin
    // Larger magnitude goes in x so the subtract path never goes negative.
    if (A[30:0] >= B[30:0]) begin
      x = A;
      y = B;
    end else begin
      x = B;
      y = A;
    end
    mx    = {1'b1, x.man, 3'b000};
    my    = {1'b1, y.man, 3'b000};
    shamt = x.exp - y.exp;
    lost  = '0;
    if (shamt >= 8'd27) begin
      my_sh = 27'd1;
    end else begin
      my_sh    = my >> shamt;
      lost     = my << (8'd27 - shamt);
      my_sh[0] = my_sh[0] | (|lost);
    end

    s  = {1'b0, mx} + {1'b0, my_sh};
    d  = mx - my_sh;
    lz = '0;
    e  = {2'b00, x.exp};
    if (x.sign == y.sign) begin
      if (s[27]) begin
        m = {s[27:2], s[1] | s[0]};
        e = e + 10'sd1;
      end else begin
        m = s[26:0];
      end
    end else begin
      for (int i = 0; i < 27; i++) begin
        if (d[i]) lz = 5'(26 - i);
      end
      m = d << lz;
      e = e - $signed({5'b00000, lz});
    end

    round_up = m[2] & (m[1] | m[0] | m[3]);
    mr       = {1'b0, m[26:3]} + {24'd0, round_up};
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'sd1;
    end

    if (m == '0 || e <= 10'sd0) begin
      result = FP_ZERO;
    end else begin
      result = {x.sign, e[7:0], mr[22:0]};
    end
  end

endmodule

// File: rtl/fadd_accum_ctrl.sv
// Reduces one window of N_TERMS float32 products plus a bias to one sum,
// guarding the shared fadder against zero operands and exact cancellation.
module fadd_accum_ctrl
  import fadd_pkg::*;
#(
  parameter int unsigned N_TERMS = 25,
  parameter bit          RELU_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bias,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  localparam int unsigned    CntW    = $clog2(N_TERMS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(N_TERMS - 1);

  state_t          state_q, state_d;
  logic [31:0]     acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     out_data_q, out_data_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic [31:0]     fadd_res;
  logic [31:0]     sum_w;

  fadder u_fadder (
    .A      (acc_q),
    .B      (in_data),
    .result (fadd_res)
  );

  always_comb begin
    if (is_zero(acc_q) && is_zero(in_data)) begin
      sum_w = FP_ZERO;
    end else if (is_zero(acc_q)) begin
      sum_w = in_data;
    end else if (is_zero(in_data)) begin
      sum_w = acc_q;
    end else if (acc_q[30:0] == in_data[30:0] && acc_q[31] != in_data[31]) begin
      // fadder cannot normalise an all-zero mantissa.
      sum_w = FP_ZERO;
    end else begin
      sum_w = fadd_res;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = bias;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        // in_ready_q is high throughout ACCUM, so in_valid alone is the handshake.
        if (in_valid) begin
          acc_d = sum_w;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d    = DONE;
            out_data_d = (RELU_EN && sum_w[31]) ? FP_ZERO : sum_w;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == ACCUM) || (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= FP_ZERO;
      cnt_q       <= '0;
      out_data_q  <= FP_ZERO;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fadd_accum_ctrl.sv
// Directed and randomized checks of fadd_accum_ctrl against an exact
// half-integer arithmetic model; two instances cover N_TERMS=4/ReLU and N_TERMS=1/no ReLU.
module tb_fadd_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
  logic [31:0] bias_a, in_data_a, out_data_a;
  logic        start_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
  logic [31:0] bias_b, in_data_b, out_data_b;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] p_a   [4];
  int          bub_a [4];

  always #5 clk = ~clk;

  fadd_accum_ctrl #(.N_TERMS(4), .RELU_EN(1'b1)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .start     (start_a),
    .bias      (bias_a),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .in_data   (in_data_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready_a),
    .out_data  (out_data_a),
    .busy      (busy_a)
  );

  fadd_accum_ctrl #(.N_TERMS(1), .RELU_EN(1'b0)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .start     (start_b),
    .bias      (bias_b),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .in_data   (in_data_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .out_data  (out_data_b),
    .busy      (busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Float32 encoding of h/2 for small integers h.
  function automatic logic [31:0] enc_half(input int h);
    int          mag;
    int          p;
    logic [31:0] shifted;
    logic [31:0] r;
    if (h == 0) return 32'h0;
    mag = (h < 0) ? -h : h;
    p   = 0;
    for (int i = 0; i < 24; i++) if (mag >= (1 << i)) p = i;
    shifted    = 32'(mag) << (23 - p);
    r[31]      = (h < 0);
    r[30:23]   = 8'(p - 1 + 127);
    r[22:0]    = shifted[22:0];
    return r;
  endfunction

  // One window on instance A using p_a/bub_a; hold cycles in DONE before out_ready.
  task automatic run_a(input logic [31:0] b, input int hold, input bit poke,
                       input logic [31:0] exp, input string tag);
    bias_a  = b;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < bub_a[i]; j++) tick();
      check($sformatf("%s.rdy%0d", tag, i), {31'd0, in_ready_a}, 32'd1);
      check($sformatf("%s.nov%0d", tag, i), {31'd0, out_valid_a}, 32'd0);
      in_valid_a = 1'b1;
      in_data_a  = p_a[i];
      tick();
      in_valid_a = 1'b0;
    end
    check({tag, ".ovalid"}, {31'd0, out_valid_a}, 32'd1);
    check({tag, ".rdy_lo"}, {31'd0, in_ready_a}, 32'd0);
    check({tag, ".busy"}, {31'd0, busy_a}, 32'd1);
    check({tag, ".data"}, out_data_a, exp);
    for (int j = 0; j < hold; j++) begin
      start_a = poke && (j % 3 == 0);
      tick();
      check($sformatf("%s.hold%0d", tag, j), {out_valid_a, out_data_a[30:0]},
            {1'b1, exp[30:0]});
    end
    start_a     = poke;
    out_ready_a = 1'b1;
    tick();
    out_ready_a = 1'b0;
    start_a     = 1'b0;
    check({tag, ".ov_lo"}, {31'd0, out_valid_a}, 32'd0);
    check({tag, ".idle"}, {30'd0, busy_a, in_ready_a}, 32'd0);
  endtask

  initial begin
    int h;
    int hb;
    int total;
    rst         = 1'b1;
    start_a     = 1'b0;
    bias_a      = '0;
    in_valid_a  = 1'b0;
    in_data_a   = '0;
    out_ready_a = 1'b0;
    start_b     = 1'b0;
    bias_b      = '0;
    in_valid_b  = 1'b0;
    in_data_b   = '0;
    out_ready_b = 1'b0;
    tick();
    tick();
    check("reset.a", {in_ready_a, out_valid_a, busy_a, out_data_a[28:0]}, 32'd0);
    check("reset.b", {in_ready_b, out_valid_b, busy_b, out_data_b[28:0]}, 32'd0);
    rst = 1'b0;
    tick();

    // Four 1.0 products, in_valid held.
    p_a   = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
    bub_a = '{0, 0, 0, 0};
    run_a(32'h0000_0000, 0, 1'b0, 32'h4080_0000, "ones");

    // Bubbled stream with a trailing zero product.
    p_a   = '{32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'h0000_0000};
    bub_a = '{0, 2, 1, 0};
    run_a(32'h3F00_0000, 0, 1'b0, 32'h4080_0000, "bubbles");

    // Exact cancellation mid-window.
    p_a   = '{32'hBF80_0000, 32'h4040_0000, 32'h0000_0000, 32'h0000_0000};
    bub_a = '{0, 0, 0, 0};
    run_a(32'h3F80_0000, 0, 1'b0, 32'h4040_0000, "cancel");

    // Negative sum clamped by ReLU.
    p_a = '{32'hC000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    run_a(32'h0000_0000, 0, 1'b0, 32'h0000_0000, "relu");

    // Long DONE stall with start pulses that must be ignored.
    p_a = '{32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 32'hBF00_0000};
    run_a(32'h3F00_0000, 10, 1'b1, 32'h4080_0000, "stall");
    tick();
    check("stall.no_restart", {31'd0, busy_a}, 32'd0);

    // Reset after two terms, with a product in flight.
    bias_a  = 32'h4000_0000;
    start_a = 1'b1;
    tick();
    start_a    = 1'b0;
    in_valid_a = 1'b1;
    in_data_a  = 32'h3F80_0000;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    in_valid_a = 1'b0;
    check("midrst.ctl", {29'd0, in_ready_a, out_valid_a, busy_a}, 32'd0);
    check("midrst.data", out_data_a, 32'd0);
    p_a = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
    run_a(32'h4000_0000, 0, 1'b0, 32'h40C0_0000, "after_rst");

    // Randomized windows against the half-integer model.
    for (int w = 0; w < 25; w++) begin
      hb    = int'($urandom_range(0, 80)) - 40;
      total = hb;
      for (int i = 0; i < 4; i++) begin
        h      = int'($urandom_range(0, 32)) - 16;
        total += h;
        p_a[i]  = enc_half(h);
        bub_a[i] = int'($urandom_range(0, 2));
      end
      run_a(enc_half(hb), int'($urandom_range(0, 3)), 1'b0,
            (total < 0) ? 32'h0 : enc_half(total), $sformatf("rnd%0d", w));
    end

    // N_TERMS=1 without ReLU, directed then random.
    for (int w = 0; w < 6; w++) begin
      hb = (w == 0) ? 0 : int'($urandom_range(0, 40)) - 20;
      h  = (w == 0) ? -4 : int'($urandom_range(0, 40)) - 20;
      bias_b  = enc_half(hb);
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      check($sformatf("n1_%0d.rdy", w), {31'd0, in_ready_b}, 32'd1);
      in_valid_b = 1'b1;
      in_data_b  = enc_half(h);
      tick();
      in_valid_b = 1'b0;
      check($sformatf("n1_%0d.ovalid", w), {30'd0, out_valid_b, in_ready_b}, 32'd2);
      check($sformatf("n1_%0d.data", w), out_data_b,
            (w == 0) ? 32'hC000_0000 : enc_half(hb + h));
      out_ready_b = 1'b1;
      tick();
      out_ready_b = 1'b0;
      check($sformatf("n1_%0d.idle", w), {31'd0, busy_b}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fadd_accum_ctrl.md
Name: fadd_accum_ctrl

Overview:
Sequencer that reduces one convolution window of N_TERMS float32 products, plus a bias, to a single float32 sum using one fadder instance. Sits between the multiplier stage and the output-feature-map writer.
Products arrive on a valid/ready stream; the finished sum is presented on a valid/ready output. The block guards fadder against its unsupported operand cases (zero operands, exact cancellation) and optionally applies ReLU.

Parameters:
N_TERMS, 25, number of products per window (5x5 kernel); legal range 1..255.
RELU_EN, 1, 1: negative sums are clamped to +0.0 on output; 0: output is passed unchanged.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous reset, active-high.
start  in  1  single-cycle pulse that begins a window; sampled only in IDLE.
bias  in  32  float32 bias, captured on start.
in_valid  in  1  product valid.
in_ready  out  1  product accepted when in_valid && in_ready.
in_data  in  32  float32 product.
out_valid  out  1  sum valid.
out_ready  in  1  downstream accepts.
out_data  out  32  float32 sum (after ReLU if enabled).
busy  out  1  high in ACCUM and DONE.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, acc=0, cnt=0, state=IDLE.
- State IDLE: on start, acc<=bias, cnt<=0, go to ACCUM. Without start, stay in IDLE.
- State ACCUM: in_ready=1 (registered-state decode, no combinational path from in_valid).
  - On handshake: acc<=sum(acc,in_data); cnt<=cnt+1.
  - When the handshake has cnt==N_TERMS-1, go to DONE. out_data is loaded in the same edge.
  - No handshake means no change. Bubbles of any length are allowed.
- State DONE: out_valid=1 and out_data stay stable until out_ready. The out handshake returns to IDLE.
- Latency: 1 cycle per accepted term. out_valid rises on the cycle after the last term handshake. Best case is N_TERMS+1 cycles from start to out_valid.
- sum(a,b) rules, with "zero" meaning exponent field == 0 (denormals are treated as zero):
  - a zero and b zero -> 0x00000000.
  - a zero only -> b; b zero only -> a. fadder is bypassed in both cases.
  - a[30:0]==b[30:0] with a[31]!=b[31] -> 0x00000000. fadder is bypassed because it cannot normalise a zero mantissa.
  - Otherwise -> fadder.result with fadder.A=acc, fadder.B=in_data.
  - fadder is purely combinational. The only timing path is acc -> fadder -> acc register.
- ReLU (RELU_EN=1): at the DONE load, if the sum has bit31=1 then out_data=0x00000000.
- Counter width is $clog2(N_TERMS+1). For N_TERMS=1, the first handshake goes directly to DONE.
- start while busy is ignored (no restart, no queuing).
- start and out handshake in the same cycle: start is ignored because the state is DONE, not IDLE.
- rst mid-window: the partial sum is discarded, all outputs take their reset values, and the in-flight product is not accepted.
- Inf/NaN are not handled. Overflow behaviour is whatever fadder produces.

Decomposition:
- Package fadd_pkg:
  - typedef fp32_t (packed sign/exp[7:0]/man[22:0]).
  - localparam FP_ZERO=32'h0000_0000.
  - enum state_t {IDLE, ACCUM, DONE}.
  - function is_zero(fp32_t).
- One sub-module: fadder, instantiated once. Bypass muxing stays in this block; fadder is not modified.

Test Plan:
- N_TERMS=4, bias=0x00000000, four products of 0x3F800000 (1.0), in_valid held high -> out_data=0x40800000 (4.0); out_valid on cycle 5 after start; in_ready low after the 4th handshake.
- N_TERMS=3, bias=0x3F000000 (0.5), products 1.0, 2.0 (0x40000000), 0.5, with in_valid toggling 1-0-0-1-0-1 -> out_data=0x40800000 (4.0); acc unchanged during bubbles.
- N_TERMS=2, bias=0x3F800000, products 0xBF800000 then 0x40400000 (3.0) -> the intermediate cancels to 0x00000000 without hang, final=0x40400000.
- RELU_EN=1, N_TERMS=1, bias=0x00000000, product 0xC0000000 (-2.0) -> out_data=0x00000000. With RELU_EN=0 -> 0xC0000000.
- out_ready held low 10 cycles in DONE, with start pulsed meanwhile -> out_data stable, start ignored. Release out_ready -> IDLE next cycle, busy=0.
- rst asserted after 2 of 4 terms -> next cycle all outputs at reset values. A new start runs a full 4-term window, and the result is unaffected by the earlier partial sum.
